truth_table_sequencer: RTL

//  Sequencer that exercises the 4-input/2-output combinational logic unit (inputs A,B,C,D; outputs F1,F2).
//  On start it drives all 16 input vectors in order, waits a settle time, and captures F1/F2 per vector.
//  It compares each capture against golden truth tables and reports pass, error count and first failing index.

---
 rtl/truth_table_sequencer_pkg.sv | 33 +++
 rtl/truth_table_sequencer_if.sv | 34 +++
 rtl/truth_table_sequencer_settle_timer.sv | 48 ++++
 rtl/truth_table_sequencer.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/truth_table_sequencer_pkg.sv
// Shared types and constants for the truth-table sequencer.
//   state_e    : sequencer FSM states
//   vec_t      : {A,B,C,D} stimulus vector, A is the MSB
//   EXP_*_DEF  : golden truth tables, bit i = expected output for vector i
package tt_seq_pkg;

    localparam int unsigned NUM_VEC = 16;
    localparam int unsigned IDX_W   = 4;
    localparam int unsigned ERR_W   = 5;

    localparam logic [NUM_VEC-1:0] EXP_F1_DEF = 16'hFF5E;
    localparam logic [NUM_VEC-1:0] EXP_F2_DEF = 16'hAAFA;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRIVE  = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    typedef struct packed {
        logic a;
        logic b;
        logic c;
        logic d;
    } vec_t;

    // Vector index to {A,B,C,D}; index bit 3 lands on A.
    function automatic vec_t idx_to_vec(input logic [IDX_W-1:0] idx);
        return vec_t'(idx);
    endfunction

endpackage

// File: rtl/truth_table_sequencer_if.sv
// Board/logic-unit side signals of the truth-table sequencer.
//   master : board side (drives start and the unit's F1/F2, observes status)
//   slave  : sequencer side
interface truth_table_sequencer_if;
    import tt_seq_pkg::*;

    logic                 start;
    logic                 vec_a;
    logic                 vec_b;
    logic                 vec_c;
    logic                 vec_d;
    logic                 f1_in;
    logic                 f2_in;
    logic                 busy;
    logic                 done;
    logic                 pass;
    logic [ERR_W-1:0]     err_count;
    logic [IDX_W-1:0]     first_err_idx;
    logic [NUM_VEC-1:0]   cap_f1;
    logic [NUM_VEC-1:0]   cap_f2;

    modport master (
        output start, f1_in, f2_in,
        input  vec_a, vec_b, vec_c, vec_d, busy, done, pass,
               err_count, first_err_idx, cap_f1, cap_f2
    );

    modport slave (
        input  start, f1_in, f2_in,
        output vec_a, vec_b, vec_c, vec_d, busy, done, pass,
               err_count, first_err_idx, cap_f1, cap_f2
    );

endinterface

// File: rtl/truth_table_sequencer_settle_timer.sv
// Settle timer: load_i restarts the count, en_i advances it; tc_o is high
// during the SETTLE_CYCLES-th enabled cycle after a load.
//   clk, rst_n : clock, async active-low reset
//   load_i     : restart count (takes priority over en_i)
//   en_i       : count enable
//   tc_o       : registered terminal-count flag
module settle_timer #(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load_i,
    input  logic en_i,
    output logic tc_o
);

    localparam int unsigned CNT_W = $clog2(SETTLE_CYCLES + 2);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(SETTLE_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tc_q, tc_d;

    // tc is precomputed one cycle ahead so it can stay a plain register.
    always_comb begin
        cnt_d = cnt_q;
        tc_d  = tc_q;
        if (load_i) begin
            cnt_d = '0;
            tc_d  = (LAST == '0);
        end else if (en_i) begin
            cnt_d = cnt_q + CNT_W'(1);
            tc_d  = (cnt_d == LAST);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            tc_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            tc_q  <= tc_d;
        end
    end

    assign tc_o = tc_q;

endmodule

// File: rtl/truth_table_sequencer.sv
// Drives all 16 {A,B,C,D} vectors into an external 4-in/2-out logic unit,
// samples F1/F2 after a settle time and grades them against golden tables.
//   clk, rst_n : clock, async active-low reset
//   bus        : slave side of truth_table_sequencer_if
//                (start, vec_a..d, f1_in/f2_in, busy, done, pass,
//                 err_count, first_err_idx, cap_f1, cap_f2)
module truth_table_sequencer
    import tt_seq_pkg::*;
#(
    parameter int unsigned        SETTLE_CYCLES = 2,
    parameter logic [NUM_VEC-1:0] EXP_F1        = EXP_F1_DEF,
    parameter logic [NUM_VEC-1:0] EXP_F2        = EXP_F2_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    truth_table_sequencer_if.slave  bus
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VEC - 1);

    state_e               state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    vec_t                 vec_q, vec_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 pass_q, pass_d;
    logic [ERR_W-1:0]     err_q, err_d;
    logic [IDX_W-1:0]     first_q, first_d;
    logic [NUM_VEC-1:0]   cap_f1_q, cap_f1_d;
    logic [NUM_VEC-1:0]   cap_f2_q, cap_f2_d;

    logic tmr_load, tmr_en, tmr_tc;
    logic mismatch;

    settle_timer #(
        .SETTLE_CYCLES (SETTLE_CYCLES)
    ) u_settle (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (tmr_load),
        .en_i   (tmr_en),
        .tc_o   (tmr_tc)
    );

    // A vector fails once even if both outputs disagree.
    assign mismatch = (bus.f1_in != EXP_F1[idx_q]) || (bus.f2_in != EXP_F2[idx_q]);

    // Next-state, datapath updates and timer control.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        vec_d    = vec_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        pass_d   = pass_q;
        err_d    = err_q;
        first_d  = first_q;
        cap_f1_d = cap_f1_q;
        cap_f2_d = cap_f2_q;
        tmr_load = 1'b0;
        tmr_en   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d  = ST_DRIVE;
                    idx_d    = '0;
                    vec_d    = idx_to_vec('0);
                    busy_d   = 1'b1;
                    pass_d   = 1'b0;
                    err_d    = '0;
                    first_d  = '0;
                    cap_f1_d = '0;
                    cap_f2_d = '0;
                    tmr_load = 1'b1;
                end
            end
            ST_DRIVE: begin
                tmr_en = 1'b1;
                if (tmr_tc) begin
                    state_d = ST_SAMPLE;
                end
            end
            ST_SAMPLE: begin
                cap_f1_d[idx_q] = bus.f1_in;
                cap_f2_d[idx_q] = bus.f2_in;
                if (mismatch) begin
                    err_d = err_q + ERR_W'(1);
                    // err_q still zero means this is the first failing vector.
                    if (err_q == '0) begin
                        first_d = idx_q;
                    end
                end
                if (idx_q == LAST_IDX) begin
                    state_d = ST_DONE;
                    vec_d   = idx_to_vec('0);
                    done_d  = 1'b1;
                end else begin
                    state_d  = ST_DRIVE;
                    idx_d    = idx_q + IDX_W'(1);
                    vec_d    = idx_to_vec(idx_d);
                    tmr_load = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                pass_d  = (err_q == '0);
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            vec_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
            err_q    <= '0;
            first_q  <= '0;
            cap_f1_q <= '0;
            cap_f2_q <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            vec_q    <= vec_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            pass_q   <= pass_d;
            err_q    <= err_d;
            first_q  <= first_d;
            cap_f1_q <= cap_f1_d;
            cap_f2_q <= cap_f2_d;
        end
    end

    assign bus.vec_a         = vec_q.a;
    assign bus.vec_b         = vec_q.b;
    assign bus.vec_c         = vec_q.c;
    assign bus.vec_d         = vec_q.d;
    assign bus.busy          = busy_q;
    assign bus.done          = done_q;
    assign bus.pass          = pass_q;
    assign bus.err_count     = err_q;
    assign bus.first_err_idx = first_q;
    assign bus.cap_f1        = cap_f1_q;
    assign bus.cap_f2        = cap_f2_q;

endmodule
